// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the RV32I instruction encoder/loader: kind codes, opcodes, fixed funct3
// values and the loader FSM state type.
package instr_encoder_loader_pkg;

  localparam logic [2:0] KindLw   = 3'd0;
  localparam logic [2:0] KindSw   = 3'd1;
  localparam logic [2:0] KindR    = 3'd2;
  localparam logic [2:0] KindBeq  = 3'd3;
  localparam logic [2:0] KindAluI = 3'd4;
  localparam logic [2:0] KindJal  = 3'd5;

  // Same opcode values the main decoder recognises.
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Sw  = 3'b010;
  localparam logic [2:0] F3Beq = 3'b000;

  typedef enum logic {StLoad, StDone} state_e;

  // True when v is a sign-extended value of msb+1 bits (bits 31..msb all equal).
  function automatic logic fits_signed(input logic [31:0] v, input int msb);
    logic ok;
    ok = 1'b1;
    for (int i = msb; i < 32; i++) begin
      if (v[i] != v[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_encoder.sv
// Combinational RV32I field-to-word formatter. With IMM_CHECK_EN defined it also flags
// immediates that do not fit their format (or odd branch/jump offsets) as not legal.
module instr_encoder
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (kind_i)
      KindLw:   word_o = {imm_i[11:0], rs1_i, F3Lw, rd_i, OpLoad};
      KindSw:   word_o = {imm_i[11:5], rs2_i, rs1_i, F3Sw, imm_i[4:0], OpStore};
      KindR:    word_o = {1'b0, funct7b5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OpRtype};
      KindBeq:  word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3Beq, imm_i[4:1], imm_i[11],
                          OpBranch};
      KindAluI: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OpImm};
      KindJal:  word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OpJal};
      default:  legal_o = 1'b0;
    endcase
`ifdef IMM_CHECK_EN
    case (kind_i)
      KindLw, KindSw, KindAluI: if (!fits_signed(imm_i, 11)) legal_o = 1'b0;
      KindBeq: if (!fits_signed(imm_i, 12) || imm_i[0]) legal_o = 1'b0;
      KindJal: if (!fits_signed(imm_i, 20) || imm_i[0]) legal_o = 1'b0;
      default: ;
    endcase
`endif
  end

`ifndef IMM_CHECK_EN
  // Upper immediate bits are silently truncated when range checking is off.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm_i[31:21];
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction memory preloader: encodes one RV32I instruction per cycle and writes it to
// consecutive word addresses. Optional immediate range checking via IMM_CHECK_EN.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              finish,
  output logic              imem_we,
  output logic [ADDR_W+1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] One    = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic              fin_pend_q, fin_pend_d;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   ptr_q, count_q;
  logic              err_q;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;
  logic [ADDR_W-1:0] waddr;

  instr_encoder u_encoder (
    .kind_i     (in_kind),
    .funct3_i   (in_funct3),
    .funct7b5_i (in_funct7b5),
    .rd_i       (in_rd),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .imm_i      (in_imm),
    .word_o     (enc_word),
    .legal_o    (enc_legal)
  );

  // count already includes the write in flight, so it doubles as full_next.
  assign full     = (count_q == DepthW);
  assign in_ready = (state_q == StLoad) && !full && !fin_pend_q;
  assign accept   = in_valid && in_ready;

  // A finish that coincides with an accept waits one cycle so that word reaches memory first.
  always_comb begin
    state_d    = state_q;
    fin_pend_d = fin_pend_q;
    case (state_q)
      StLoad: begin
        if (finish || fin_pend_q) begin
          if (accept) begin
            fin_pend_d = 1'b1;
          end else begin
            state_d    = StDone;
            fin_pend_d = 1'b0;
          end
        end
      end
      StDone: ;
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StLoad;
      fin_pend_q <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fin_pend_q <= fin_pend_d;
      we_q       <= accept && enc_legal;
      if (accept && enc_legal) begin
        wdata_q <= enc_word;
        count_q <= count_q + One;
      end
      if (accept && !enc_legal) err_q <= 1'b1;
      if (we_q && (ptr_q != DepthW)) ptr_q <= ptr_q + One;
    end
  end

  // Once the pointer saturates at DEPTH the address holds at the last word.
  assign waddr      = ptr_q[ADDR_W] ? '1 : ptr_q[ADDR_W-1:0];
  assign imem_addr  = {waddr, 2'b00};
  assign imem_we    = we_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign done       = (state_q == StDone);
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed encodings and boundaries plus a
// randomized run against a transaction-level reference model.
module tb_instr_encoder_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_kind = '0;
  logic [2:0]        in_funct3 = '0;
  logic              in_funct7b5 = 1'b0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic [31:0]       in_imm = '0;
  logic              finish = 1'b0;
  logic              imem_we;
  logic [ADDR_W+1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  instr_encoder_loader #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_kind     (in_kind),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .finish      (finish),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .count       (count),
    .full        (full),
    .done        (done),
    .err         (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference encoding built arithmetically from the RV32I field positions.
  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic logic [31:0] ref_word(input logic [2:0] k, input logic [2:0] f3,
                                           input logic f7, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
    logic [31:0] r1, r2, d;
    r1 = 32'(rs1) << 15;
    r2 = 32'(rs2) << 20;
    d  = 32'(rd) << 7;
    case (k)
      3'd0: return 32'h03 + d + (32'd2 << 12) + r1 + (fld(imm, 11, 0) << 20);
      3'd1: return 32'h23 + (fld(imm, 4, 0) << 7) + (32'd2 << 12) + r1 + r2
                   + (fld(imm, 11, 5) << 25);
      3'd2: return 32'h33 + d + (32'(f3) << 12) + r1 + r2 + (f7 ? 32'h4000_0000 : 32'd0);
      3'd3: return 32'h63 + (fld(imm, 11, 11) << 7) + (fld(imm, 4, 1) << 8) + r1 + r2
                   + (fld(imm, 10, 5) << 25) + (fld(imm, 12, 12) << 31);
      3'd4: return 32'h13 + d + (32'(f3) << 12) + r1 + (fld(imm, 11, 0) << 20);
      default: return 32'h6f + d + (fld(imm, 19, 12) << 12) + (fld(imm, 11, 11) << 20)
                      + (fld(imm, 10, 1) << 21) + (fld(imm, 20, 20) << 31);
    endcase
  endfunction

  function automatic bit ref_legal(input logic [2:0] k, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    if (k > 3'd5) return 1'b0;
`ifdef IMM_CHECK_EN
    case (k)
      3'd0, 3'd1, 3'd4: return (s >= -2048) && (s <= 2047);
      3'd3: return (s >= -4096) && (s <= 4095) && !imm[0];
      3'd5: return (s >= -(1 << 20)) && (s < (1 << 20)) && !imm[0];
      default: return 1'b1;
    endcase
`else
    return (s == s);
`endif
  endfunction

  // Transaction-level model: words accepted, words written, pending write, flags.
  int          m_count = 0;
  int          m_ptr = 0;
  bit          m_we = 0, m_err = 0, m_done = 0, m_pend = 0;
  logic [31:0] m_wdata = '0;
  bit          m_ready, m_acc;

  always @(negedge clk) begin
    m_ready = !m_done && !m_pend && (m_count < DEPTH);
    check("we", imem_we, m_we);
    check("count", count, m_count);
    check("full", full, m_count == DEPTH);
    check("done", done, m_done);
    check("err", err, m_err);
    check("ready", in_ready, m_ready);
    check("wdata", imem_wdata, m_wdata);
    if (m_ptr < DEPTH) check("addr", imem_addr, m_ptr * 4);
    if (reset) begin
      m_count = 0; m_ptr = 0; m_we = 0; m_err = 0; m_done = 0; m_pend = 0; m_wdata = '0;
    end else begin
      m_acc = in_valid && m_ready;
      if (m_we) m_ptr++;
      m_we = 0;
      if (m_acc) begin
        if (ref_legal(in_kind, in_imm)) begin
          m_we    = 1;
          m_wdata = ref_word(in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm);
          m_count++;
        end else begin
          m_err = 1;
        end
      end
      if (!m_done && (finish || m_pend)) begin
        if (m_acc) m_pend = 1;
        else begin
          m_done = 1;
          m_pend = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    in_kind = k; in_funct3 = f3; in_funct7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    finish   = 1'b0;
  endtask

  task automatic expect_wr(input string tag, input logic [31:0] addr, input logic [31:0] word);
    @(negedge clk);
    check({tag, "_we"}, imem_we, 1);
    check({tag, "_addr"}, imem_addr, addr);
    check({tag, "_word"}, imem_wdata, word);
  endtask

  int          nwe;
  logic [31:0] last_addr;
  logic [2:0]  rk;

  initial begin
    tick();
    tick();
    @(negedge clk);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // addi / lw / sw back-to-back
    tick(); reset = 1'b0;
    drive(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick(); drive(3'd0, 3'd0, 1'b0, 5'd2, 5'd1, 5'd0, 32'd8);
    expect_wr("addi", 32'h0, 32'h0050_0093);
    tick(); drive(3'd1, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12);
    expect_wr("lw", 32'h4, 32'h0080_A103);
    tick(); idle();
    expect_wr("sw", 32'h8, 32'h0020_A623);
    check("count3", count, 3);

    // beq, jal, add, sub
    tick(); drive(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    tick(); drive(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16);
    expect_wr("beq", 32'hC, 32'h0020_8463);
    tick(); drive(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_wr("jal", 32'h10, 32'h0100_00EF);
    tick(); drive(3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_wr("add", 32'h14, 32'h0020_81B3);
    tick(); idle();
    expect_wr("sub", 32'h18, 32'h4020_81B3);

    // illegal kind, then next legal word at the next free address
    tick(); drive(3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
    tick(); idle();
    @(negedge clk);
    check("ill_err", err, 1);
    check("ill_we", imem_we, 0);
    check("ill_count", count, 7);
    tick(); drive(3'd4, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    tick(); idle();
    expect_wr("post_ill", 32'h1C, 32'hFFF0_0293);

`ifdef IMM_CHECK_EN
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    drive(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    tick(); idle();
    @(negedge clk);
    check("beq_odd_err", err, 1);
    check("beq_odd_we", imem_we, 0);
    check("beq_odd_count", count, 0);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    drive(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096);
    tick(); idle();
    @(negedge clk);
    check("addi_big_err", err, 1);
    check("addi_big_we", imem_we, 0);
    check("addi_big_count", count, 0);
`endif

    // fill the whole memory with in_valid held high
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    drive(3'd4, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd1);
    nwe = 0;
    last_addr = '0;
    repeat (DEPTH + 4) begin
      @(negedge clk);
      if (imem_we) begin
        nwe++;
        last_addr = 32'(imem_addr);
      end
    end
    check("fill_writes", nwe, DEPTH);
    check("fill_last_addr", last_addr, (DEPTH - 1) * 4);
    check("fill_full", full, 1);
    check("fill_ready", in_ready, 0);
    check("fill_count", count, DEPTH);

    // finish together with an accept
    tick(); idle(); reset = 1'b1;
    tick(); reset = 1'b0;
    drive(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
    finish = 1'b1;
    tick(); idle();
    @(negedge clk);
    check("fin_we", imem_we, 1);
    check("fin_word", imem_wdata, 32'h0070_0093);
    check("fin_done_early", done, 0);
    tick();
    @(negedge clk);
    check("fin_done", done, 1);
    check("fin_ready", in_ready, 0);

    // reset at the edge that would accept a second word
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    drive(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
    tick(); drive(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd9);
    reset = 1'b1;
    tick(); idle(); reset = 1'b0;
    @(negedge clk);
    check("rstp_we", imem_we, 0);
    check("rstp_count", count, 0);
    check("rstp_wdata", imem_wdata, 0);
    check("rstp_addr", imem_addr, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset    = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      finish   = ($urandom_range(0, 59) == 0);
      rk = ($urandom_range(0, 15) == 0) ? 3'(6 + $urandom_range(0, 1))
                                        : 3'($urandom_range(0, 5));
      in_kind     = rk;
      in_funct3   = 3'($urandom_range(0, 7));
      in_funct7b5 = (rk == 3'd2) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_rd       = 5'($urandom_range(0, 31));
      in_rs1      = 5'($urandom_range(0, 31));
      in_rs2      = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0: in_imm = 32'($urandom_range(0, 63)) - 32'd32;
        1: in_imm = 32'($urandom_range(0, 10000)) - 32'd5000;
        default: in_imm = $urandom;
      endcase
    end
    tick(); idle(); reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
